// File: rtl/dmem_port_driver_if.sv
// dmem_port_driver_if: core-side load/store request and response handshake
interface dmem_port_driver_if;
  logic req_valid, req_ready, req_we, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_port_driver.sv
// dmem_port_driver: turns one RV32 load/store into one byte-masked SRAM access
module dmem_port_driver #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_port_driver_if.slave     bus,
  output logic                  mem_csb_o,
  output logic                  mem_web_o,
  output logic [3:0]            mem_wmask_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_din_o,
  input  logic [31:0]           mem_dout_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, READ, RESP} state_t;
  state_t state_q, state_d;
  logic csb_q, csb_d, web_q, web_d;
  logic [3:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] din_q, din_d, rdata_q, rdata_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic uns_q, uns_d, we_q, we_d, fault_q, fault_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic fault;
  logic [1:0] off;
  logic [3:0] st_mask;
  logic [31:0] st_din, sh, ld_data;
  assign off = bus.req_addr[1:0];
  assign fault = (bus.req_size == 2'd3) | (bus.req_size == 2'd1 & off[0]) |
                 (bus.req_size == 2'd2 & |off) | (|bus.req_addr[31:ADDR_WIDTH+2]);
  assign st_mask = !bus.req_we ? 4'b0000 :
                   bus.req_size == 2'd0 ? 4'b0001 << off :
                   bus.req_size == 2'd1 ? 4'b0011 << off : 4'b1111;
  assign st_din = bus.req_size == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                  bus.req_size == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  // Returned word is shifted so the addressed lane lands at bit 0 before extension
  assign sh = mem_dout_i >> {off_q, 3'b000};
  assign ld_data = size_q == 2'd0 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
                   size_q == 2'd1 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
  always_comb begin
    state_d = state_q;
    csb_d = csb_q;
    web_d = web_q;
    wmask_d = wmask_q;
    addr_d = addr_q;
    din_d = din_q;
    size_d = size_q;
    off_d = off_q;
    uns_d = uns_q;
    we_d = we_q;
    fault_d = fault_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d = rsp_err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        // Faults still pass through ACCESS, unselected, so every store-like reply lands at E1
        state_d = ACCESS;
        fault_d = fault;
        we_d = bus.req_we;
        size_d = bus.req_size;
        off_d = off;
        uns_d = bus.req_unsigned;
        csb_d = fault;
        if (!fault) begin
          web_d = ~bus.req_we;
          wmask_d = st_mask;
          addr_d = bus.req_addr[ADDR_WIDTH+1:2];
          din_d = st_din;
        end
      end
      ACCESS: begin
        csb_d = 1'b1;
        web_d = 1'b1;
        state_d = (fault_q | we_q) ? RESP : READ;
        rsp_valid_d = fault_q | we_q;
        rsp_err_d = fault_q;
        rdata_d = '0;
      end
      READ: begin
        state_d = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d = 1'b0;
        rdata_d = ld_data;
      end
      default: if (bus.rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      csb_q <= 1'b1;
      web_q <= 1'b1;
      wmask_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      size_q <= '0;
      off_q <= '0;
      uns_q <= 1'b0;
      we_q <= 1'b0;
      fault_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      csb_q <= csb_d;
      web_q <= web_d;
      wmask_q <= wmask_d;
      addr_q <= addr_d;
      din_q <= din_d;
      size_q <= size_d;
      off_q <= off_d;
      uns_q <= uns_d;
      we_q <= we_d;
      fault_q <= fault_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rdata_q <= rdata_d;
    end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.rsp_rdata = rdata_q;
  assign mem_csb_o = csb_q;
  assign mem_web_o = web_q;
  assign mem_wmask_o = wmask_q;
  assign mem_addr_o = addr_q;
  assign mem_din_o = din_q;
endmodule

// File: tb/tb_dmem_port_driver.sv
// tb_dmem_port_driver: random load/store traffic against a byte-array memory model
module tb_dmem_port_driver;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_csb, mem_web;
  logic [3:0] mem_wmask;
  logic [7:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  int n_chk = 0, n_fail = 0;
  dmem_port_driver_if bus ();
  dmem_port_driver #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_csb_o(mem_csb), .mem_web_o(mem_web), .mem_wmask_o(mem_wmask),
    .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  // SRAM behaviour: inputs captured on the rising edge while selected
  logic [31:0] sram [0:255];
  logic init_done = 1'b0;
  int acc_cnt = 0;
  always @(posedge clk)
    if (!init_done) begin
      for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (!mem_csb) begin
      acc_cnt <= acc_cnt + 1;
      if (!mem_web) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end else mem_dout <= sram[mem_addr];
    end
  logic [7:0] ref_b [0:1023];
  initial for (int i = 0; i < 1024; i++) ref_b[i] = 8'(init_word(i / 4) >> (8 * (i % 4)));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int n, lat, acc0;
    logic f;
    logic [31:0] exp_mask, exp_din, exp_rd, held;
    n = 1 << size;
    f = size == 3 || (size == 1 && addr[0]) || (size == 2 && addr % 4 != 0) || addr >= 1024;
    exp_mask = 0;
    exp_din = 0;
    exp_rd = 0;
    if (!f) begin
      for (int i = 0; i < n; i++) if (we) exp_mask |= 32'(1) << (addr % 4 + 32'(i));
      for (int j = 0; j < 4; j++) exp_din |= ((wdata >> (8 * (j % n))) & 32'hFF) << (8 * j);
      if (!we) begin
        for (int i = 0; i < n; i++) exp_rd |= 32'(ref_b[addr + 32'(i)]) << (8 * i);
        if (!uns && n < 4 && exp_rd[8*n-1]) exp_rd |= 32'hFFFFFFFF << (8 * n);
      end
    end
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = size;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b0;
    acc0 = acc_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_we = 1'($urandom);
    bus.req_size = 2'($urandom);
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    bus.rsp_ready = 1'($urandom);
    check("e0_csb", 32'(mem_csb), 32'(f));
    if (!f) begin
      check("e0_web", 32'(mem_web), 32'(!we));
      check("e0_wmask", 32'(mem_wmask), exp_mask);
      check("e0_addr", 32'(mem_addr), addr / 4);
      if (we) check("e0_din", mem_din, exp_din);
    end
    if (we && !f) for (int i = 0; i < n; i++) ref_b[addr + 32'(i)] = 8'(wdata >> (8 * i));
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) check("e1_csb_web", {mem_csb, mem_web}, 2'b11);
    end while (!bus.rsp_valid && lat < 6);
    bus.rsp_ready = 1'b0;
    check("latency", lat, (f || we) ? 1 : 2);
    check("rsp_err", 32'(bus.rsp_err), 32'(f));
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    check("accesses", acc_cnt - acc0, f ? 0 : 1);
    held = bus.rsp_rdata;
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold", {bus.rsp_valid, bus.req_ready, bus.rsp_rdata[29:0]}, {2'b10, held[29:0]});
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("back_idle", {bus.rsp_valid, bus.req_ready}, 2'b01);
    bus.rsp_ready = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check(tag, {mem_csb, mem_web, mem_wmask, mem_addr, bus.rsp_valid, bus.rsp_err, bus.req_ready},
          {2'b11, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1});
    check({tag, "_data"}, mem_din | bus.rsp_rdata, 0);
  endtask
  task automatic reset_store(input logic [31:0] addr, input logic [31:0] wdata, input logic after_e1);
    int acc0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'd2;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b0;
    acc0 = acc_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (after_e1) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) ref_b[addr + 32'(i)] = 8'(wdata >> (8 * i));
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_rsp_after_reset", 32'(bus.rsp_valid), 0);
    end
    check("reset_accesses", acc_cnt - acc0, 32'(after_e1));
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    do_req(1, 2, 0, 32'h10, 32'hDEADBEEF, 0);
    do_req(0, 2, 0, 32'h10, 0, 0);
    do_req(1, 0, 0, 32'h13, 32'h12345680, 1);
    do_req(0, 0, 0, 32'h13, 0, 0);
    do_req(0, 0, 1, 32'h13, 0, 0);
    do_req(0, 2, 0, 32'h10, 0, 0);
    do_req(1, 2, 0, 32'h0, 32'h8001_7FFF, 0);
    do_req(0, 1, 0, 32'h02, 0, 0);
    do_req(0, 1, 0, 32'h01, 0, 0);
    do_req(0, 2, 0, 32'h400, 0, 0);
    do_req(0, 3, 0, 32'h8, 0, 0);
    do_req(1, 1, 0, 32'h3FE, 32'hFFFF_A55A, 0);
    do_req(0, 1, 1, 32'h3FE, 0, 0);
    do_req(0, 2, 0, 32'h10, 0, 5);
    reset_store(32'h20, 32'hCAFEF00D, 1'b0);
    reset_store(32'h24, 32'h0BADC0DE, 1'b1);
    do_req(0, 2, 0, 32'h20, 0, 0);
    do_req(0, 2, 0, 32'h24, 0, 0);
    for (int k = 0; k < 120; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3));
    end
    for (int i = 0; i < 256; i++)
      check("sram_word", sram[i], {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
